operand_forward_stage: RTL
==========================

# operand_forward_stage

Execute-stage operand selector and ID/EX operand register that sits directly downstream of `forwarding_unit`. It consumes the per-operand source codes `rs1_src`/`rs2_src`, plus the `busy` (load-use) and `invalid` (rs2 not a register) flags. From these it selects each ALU operand from the register file, the two most recent ALU results, or memory read data, and registers the result for the ALU. On a load-use hazard it inserts exactly one bubble and raises a stall to the fetch/decode stages.

## Interface

**Parameters**
- `XLEN`, default 32: operand/data width.

**Ports**
- `clk` in 1: single clock. All state updates on the rising edge.
- `reset2` in 1: synchronous, active-high reset.
- `in_valid` in 1: a decoded instruction is present this cycle.
- `rs1_src` in 2: source code for operand A (0 reg, 1 alu_1, 2 alu_2, 3 mem).
- `rs2_src` in 2: source code for operand B (same encoding).
- `busy` in 1: load-use hazard on the current instruction.
- `invalid` in 1: rs2 field is not a register; suppress forwarding on B.
- `rs1_data` in XLEN: register-file read, port 1.
- `rs2_data` in XLEN: register-file read, port 2.
- `alu_q1` in XLEN: ALU result from the previous cycle.
- `alu_q2` in XLEN: ALU result from two cycles ago.
- `mem_rdata` in XLEN: data-memory read data.
- `op_a` out XLEN: registered operand A.
- `op_b` out XLEN: registered operand B.
- `out_valid` out 1: `op_a`/`op_b` hold a real instruction (0 = bubble).
- `stall` out 1: combinational; upstream must hold the instruction and PC this cycle.
- `stall_cnt` out 16: saturating stall-cycle count. Present only with `FWD_STALL_CNT_EN`.

## Operation

**States**
- `RUN`: normal operation.
- `HOLD`: one-cycle load-use recovery.

**Effective B code**
- The effective B code is `register` (0) whenever `invalid`=1, regardless of `rs2_src`.
- `invalid` has no effect on A.

**RUN, `in_valid`=1, `busy`=0**
- Mux each operand by its code.
- Register `op_a`/`op_b`; `out_valid`<=1. Stay in `RUN`.

**RUN, `in_valid`=1, `busy`=1**
- `stall`=1 this cycle.
- `out_valid`<=1'b0 (bubble). `op_a`/`op_b` hold their previous values.
- Latch the effective codes into `pend_a`/`pend_b`. Go to `HOLD`.

**RUN, `in_valid`=0**
- `out_valid`<=0. Operands hold.

**HOLD (exactly one cycle)**
- `stall`=0.
- Promote any pending code equal to `alu_1` (1) to `mem` (3); other codes are used unchanged.
- Mux using the promoted pending codes, ignoring `rs1_src`/`rs2_src`/`busy` this cycle.
- `out_valid`<=1. Return to `RUN`.

**Mux widths**
- All selections are pure XLEN-bit copies: no extension, no arithmetic.

## Timing

- **Latency:** 1 cycle from inputs to `op_a`/`op_b`/`out_valid`.
- **`stall`:** combinational. It equals `in_valid & busy & (state==RUN)`. It is never asserted in `HOLD` and never for two consecutive cycles.
- **Load-use sequence:** `busy` at cycle N → bubble visible at N+1 → forwarded instruction visible at N+2.
- **Reset values (`reset2`=1):** state=`RUN`, `op_a`=0, `op_b`=0, `out_valid`=0, `pend_a`=`pend_b`=0, `stall_cnt`=0.
- **Reset takes priority:** reset during `HOLD` discards the pending instruction; no output is produced for it.
- **`busy` with `in_valid`=0:** ignored. No stall, no state change.
- **`invalid` and `busy` together:** still stalls. B uses `rs2_data` in `HOLD`.

## Configuration

- **`FWD_STALL_CNT_EN` defined:**
  - `stall_cnt` port exists.
  - It increments by 1 on every cycle where `stall`=1.
  - It saturates at 16'hFFFF and clears on `reset2`.
- **`FWD_STALL_CNT_EN` undefined:**
  - Port and counter are absent.
  - All other behaviour is identical.

## Structure

- **Shared package `fwd_pkg`:**
  - Source-code constants `SRC_REG`=2'd0, `SRC_ALU1`=2'd1, `SRC_ALU2`=2'd2, `SRC_MEM`=2'd3.
  - State encoding `ST_RUN`=1'b0, `ST_HOLD`=1'b1.
  - `forwarding_unit` uses the same source-code constants.
- **Sub-module `operand_mux`:**
  - 4:1 XLEN-bit mux selected by a 2-bit code.
  - Instantiated twice, once for A and once for B.
  - State, pending codes, output registers and counter stay in the top level.

## Test plan

1. **Forwarding from each source:** `rs1_src`=0/1/2/3 with `rs1_data`=0x11, `alu_q1`=0x22, `alu_q2`=0x33, `mem_rdata`=0x44 → next-cycle `op_a`=0x11/0x22/0x33/0x44, `out_valid`=1.
2. **`invalid` suppresses B only:** `rs2_src`=1, `invalid`=1, `rs2_data`=0x5 → `op_b`=0x5 (A still follows `rs1_src`).
3. **Load-use stall:** `in_valid`=1, `busy`=1, `rs1_src`=1, `mem_rdata`=0xABCD →
   - `stall`=1 same cycle;
   - `out_valid`=0 at N+1;
   - `op_a`=0xABCD with `out_valid`=1 at N+2;
   - `stall`=0 at N+1.
4. **Back-to-back `busy`:** `busy` held high for 2 cycles → only one stall/bubble; the second `busy` falls in `HOLD` and is ignored.
5. **Reset during `HOLD`:** `reset2` asserted in `HOLD` → next cycle state `RUN`, `out_valid`=0, `op_a`=`op_b`=0; no delayed output appears.
6. **Counter saturation (with `FWD_STALL_CNT_EN`):** preload 0xFFFE via 2 stalls after forcing, or run 65537 stalls → `stall_cnt` stops at 0xFFFF.

Source files
------------

// File: rtl/fwd_pkg.sv
// Shared definitions for the forwarding path: operand source codes, the
// operand stage state encoding and the load-use code promotion helper.
package fwd_pkg;

  localparam logic [1:0] SRC_REG  = 2'd0;
  localparam logic [1:0] SRC_ALU1 = 2'd1;
  localparam logic [1:0] SRC_ALU2 = 2'd2;
  localparam logic [1:0] SRC_MEM  = 2'd3;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  // After one bubble, the value that was "previous ALU result" is now
  // arriving from memory, so an alu_1 dependency is served from mem.
  function automatic logic [1:0] promote_code(input logic [1:0] code);
    promote_code = (code == SRC_ALU1) ? SRC_MEM : code;
  endfunction

endpackage

// File: rtl/operand_mux.sv
// 4:1 operand selector driven by a fwd_pkg source code.
module operand_mux
  import fwd_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]      sel,
  input  logic [XLEN-1:0] reg_data,
  input  logic [XLEN-1:0] alu_q1,
  input  logic [XLEN-1:0] alu_q2,
  input  logic [XLEN-1:0] mem_rdata,
  output logic [XLEN-1:0] data
);

  always_comb begin
    data = reg_data;
    case (sel)
      SRC_REG:  data = reg_data;
      SRC_ALU1: data = alu_q1;
      SRC_ALU2: data = alu_q2;
      SRC_MEM:  data = mem_rdata;
      default:  data = reg_data;
    endcase
  end

endmodule

// File: rtl/operand_forward_stage.sv
// ID/EX operand selection and register with one-bubble load-use recovery.
// Optional saturating stall counter enabled by FWD_STALL_CNT_EN.
module operand_forward_stage
  import fwd_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset2,
  input  logic            in_valid,
  input  logic [1:0]      rs1_src,
  input  logic [1:0]      rs2_src,
  input  logic            busy,
  input  logic            invalid,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] alu_q1,
  input  logic [XLEN-1:0] alu_q2,
  input  logic [XLEN-1:0] mem_rdata,
  output logic [XLEN-1:0] op_a,
  output logic [XLEN-1:0] op_b,
  output logic            out_valid,
  output logic            stall
`ifdef FWD_STALL_CNT_EN
  , output logic [15:0]   stall_cnt
`endif
);

  state_t          state;
  logic [1:0]      pend_a;
  logic [1:0]      pend_b;
  logic [1:0]      eff_b;
  logic [1:0]      sel_a;
  logic [1:0]      sel_b;
  logic [XLEN-1:0] mux_a;
  logic [XLEN-1:0] mux_b;

  // A non-register rs2 field must never pick up a forwarded value.
  assign eff_b = invalid ? SRC_REG : rs2_src;
  assign stall = in_valid & busy & (state == ST_RUN);

  always_comb begin
    sel_a = rs1_src;
    sel_b = eff_b;
    if (state == ST_HOLD) begin
      sel_a = promote_code(pend_a);
      sel_b = promote_code(pend_b);
    end
  end

  operand_mux #(.XLEN(XLEN)) u_mux_a (
    .sel       (sel_a),
    .reg_data  (rs1_data),
    .alu_q1    (alu_q1),
    .alu_q2    (alu_q2),
    .mem_rdata (mem_rdata),
    .data      (mux_a)
  );

  operand_mux #(.XLEN(XLEN)) u_mux_b (
    .sel       (sel_b),
    .reg_data  (rs2_data),
    .alu_q1    (alu_q1),
    .alu_q2    (alu_q2),
    .mem_rdata (mem_rdata),
    .data      (mux_b)
  );

  always_ff @(posedge clk) begin
    if (reset2) begin
      state     <= ST_RUN;
      op_a      <= '0;
      op_b      <= '0;
      out_valid <= 1'b0;
      pend_a    <= SRC_REG;
      pend_b    <= SRC_REG;
    end else begin
      case (state)
        ST_RUN: begin
          if (in_valid && busy) begin
            out_valid <= 1'b0;
            pend_a    <= rs1_src;
            pend_b    <= eff_b;
            state     <= ST_HOLD;
          end else if (in_valid) begin
            op_a      <= mux_a;
            op_b      <= mux_b;
            out_valid <= 1'b1;
          end else begin
            out_valid <= 1'b0;
          end
        end
        ST_HOLD: begin
          op_a      <= mux_a;
          op_b      <= mux_b;
          out_valid <= 1'b1;
          state     <= ST_RUN;
        end
        default: state <= ST_RUN;
      endcase
    end
  end

`ifdef FWD_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (reset2) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule
